// File: rtl/onewire_pkg.sv
// Shared types and helpers for the 1-Wire slot engine.
// Optional CRC-8 output is enabled with ONEWIRE_SLOT_CRC8_EN.
package onewire_pkg;

  localparam logic OW_MODE_WRITE = 1'b0;
  localparam logic OW_MODE_READ  = 1'b1;

  // Dallas/Maxim CRC-8, reflected form of x^8+x^5+x^4+1
  localparam logic [7:0] OW_CRC8_POLY = 8'h8C;

  typedef enum logic [1:0] {
    OW_IDLE,
    OW_SLOT_LOW,
    OW_SLOT_REL,
    OW_FINISH
  } ow_state_e;

  function automatic int unsigned us_to_clks(
    input int unsigned us,
    input int unsigned clks_per_us
  );
    return us * clks_per_us;
  endfunction

endpackage

// File: rtl/onewire_crc8_bit.sv
// One-bit serial update of the Dallas/Maxim CRC-8.
// Used by the slot engine only when ONEWIRE_SLOT_CRC8_EN is defined.
module onewire_crc8_bit
  import onewire_pkg::*;
(
  input  logic [7:0] i_crc_in,
  input  logic       i_bit_in,
  output logic [7:0] o_crc_out
);

  logic w_fb;

  assign w_fb      = i_crc_in[0] ^ i_bit_in;
  assign o_crc_out = {1'b0, i_crc_in[7:1]}
                   ^ (w_fb ? OW_CRC8_POLY : 8'h00);

endmodule

// File: rtl/onewire_slot_engine.sv
// Burst 1-Wire slot engine: 1..DATA_W write or read slots, LSB first.
// Define ONEWIRE_SLOT_CRC8_EN to add a running CRC-8 output o_crc8.
module onewire_slot_engine
  import onewire_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = 27,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned T_SLOT_US   = 70,
  parameter int unsigned T_W0_LOW_US = 60,
  parameter int unsigned T_W1_LOW_US = 6,
  parameter int unsigned T_SAMPLE_US = 15,
  localparam int unsigned NB_W       = $clog2(DATA_W + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [NB_W-1:0]   i_nbits,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_bus_in,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_drive_low
`ifdef ONEWIRE_SLOT_CRC8_EN
  ,
  output logic [7:0]        o_crc8
`endif
);

  localparam int unsigned SLOT_CLKS =
    us_to_clks(T_SLOT_US, CLKS_PER_US);
  localparam int unsigned W0_CLKS =
    us_to_clks(T_W0_LOW_US, CLKS_PER_US);
  localparam int unsigned W1_CLKS =
    us_to_clks(T_W1_LOW_US, CLKS_PER_US);
  localparam int unsigned SAMP_CLKS =
    us_to_clks(T_SAMPLE_US, CLKS_PER_US);
  localparam int unsigned CNT_W = $clog2(SLOT_CLKS);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CLKS - 1);
  localparam logic [CNT_W-1:0] W0_LAST   = CNT_W'(W0_CLKS - 1);
  localparam logic [CNT_W-1:0] W1_LAST   = CNT_W'(W1_CLKS - 1);
  localparam logic [CNT_W-1:0] SAMP_AT   = CNT_W'(SAMP_CLKS - 1);
  localparam logic [NB_W-1:0]  NB_MAX    = NB_W'(DATA_W);

  ow_state_e         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode;
  logic [NB_W-1:0]   r_left;
  logic [DATA_W-1:0] r_wsh;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_rdata;
  logic              r_busy;
  logic              r_done;
  logic              r_drive;

  logic [NB_W-1:0]   w_nb;
  logic              w_long_low;
  logic              w_low_last;
  logic              w_samp;
  logic              w_slot_last;
  logic              w_accept;

  assign w_nb = (i_nbits > NB_MAX) ? NB_MAX : i_nbits;

  // Only a write-0 slot holds the bus for the long low time.
  assign w_long_low  = (r_mode == OW_MODE_WRITE) && !r_wsh[0];
  assign w_low_last  = w_long_low ? (r_cnt == W0_LAST)
                                  : (r_cnt == W1_LAST);
  assign w_samp      = (r_mode == OW_MODE_READ) && (r_cnt == SAMP_AT);
  assign w_slot_last = (r_cnt == SLOT_LAST);
  assign w_accept    = (r_state == OW_IDLE) && i_start;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= OW_IDLE;
      r_cnt   <= '0;
      r_mode  <= OW_MODE_WRITE;
      r_left  <= '0;
      r_wsh   <= '0;
      r_mask  <= '0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drive <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        OW_IDLE: begin
          if (i_start) begin
            r_mode  <= i_mode;
            r_left  <= w_nb;
            r_wsh   <= i_wdata;
            r_mask  <= DATA_W'(1);
            r_rdata <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (w_nb == '0) begin
              r_state <= OW_FINISH;
            end else begin
              r_state <= OW_SLOT_LOW;
              r_drive <= 1'b1;
            end
          end
        end
        OW_SLOT_LOW: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_low_last) begin
            r_state <= OW_SLOT_REL;
            r_drive <= 1'b0;
          end
        end
        OW_SLOT_REL: begin
          if (w_samp && i_bus_in) begin
            r_rdata <= r_rdata | r_mask;
          end
          if (w_slot_last) begin
            r_cnt <= '0;
            if (r_left == NB_W'(1)) begin
              r_state <= OW_FINISH;
            end else begin
              r_left  <= r_left - NB_W'(1);
              r_wsh   <= r_wsh >> 1;
              r_mask  <= r_mask << 1;
              r_state <= OW_SLOT_LOW;
              r_drive <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        OW_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= OW_IDLE;
        end
        default: begin
          r_state <= OW_IDLE;
          r_drive <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_drive_low = r_drive;

`ifdef ONEWIRE_SLOT_CRC8_EN
  logic [7:0] r_crc;
  logic [7:0] w_crc_nx;
  logic       w_xbit;

  // The read bit is already in r_rdata by the slot's last cycle.
  assign w_xbit = (r_mode == OW_MODE_READ) ? |(r_rdata & r_mask)
                                           : r_wsh[0];

  onewire_crc8_bit u_crc (
    .i_crc_in  (r_crc),
    .i_bit_in  (w_xbit),
    .o_crc_out (w_crc_nx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_crc <= 8'h00;
    end else if (w_accept) begin
      r_crc <= 8'h00;
    end else if (r_state == OW_SLOT_REL && w_slot_last) begin
      r_crc <= w_crc_nx;
    end
  end

  assign o_crc8 = r_crc;
`else
  logic w_unused;
  assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_onewire_slot_engine.sv
// Scoreboard bench for onewire_slot_engine at default parameters.
// Expected pulses and done events are queued by stimulus, popped by monitors.
module tb_onewire_slot_engine;

  localparam int SLOT = 1890;
  localparam int W0   = 1620;
  localparam int W1   = 162;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] nbits = '0;
  logic [7:0] wdata = '0;
  logic       bus_in = 1'b1;
  logic       busy;
  logic       done;
  logic       drive_low;
  logic [7:0] rdata;
`ifdef ONEWIRE_SLOT_CRC8_EN
  logic [7:0] crc8;
`endif

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int at;
    int len;
  } pulse_t;

  typedef struct {
    int         at;
    logic [7:0] rd;
  } done_t;

  pulse_t exp_p[$];
  done_t  exp_d[$];

  int         rd_base = -1;
  logic [7:0] rd_mask = '0;

  onewire_slot_engine dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_mode      (mode),
    .i_nbits     (nbits),
    .i_wdata     (wdata),
    .i_bus_in    (bus_in),
    .o_busy      (busy),
    .o_done      (done),
    .o_rdata     (rdata),
    .o_drive_low (drive_low)
`ifdef ONEWIRE_SLOT_CRC8_EN
    ,
    .o_crc8      (crc8)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  // Bus model: slave pulls low only at offset 404 of masked slots;
  // decoy lows at 403 and 405 of every slot catch a misplaced sample.
  always @(negedge clk) begin
    int d;
    int off;
    int slot;
    if (rd_base >= 0 && cyc >= rd_base) begin
      d    = cyc - rd_base;
      slot = d / SLOT;
      off  = d % SLOT;
      bus_in = !((off == 404 && slot < 8 && rd_mask[slot])
                 || off == 403 || off == 405);
    end else begin
      bus_in = 1'b1;
    end
  end

  int p_start = -1;
  always @(negedge clk) begin
    pulse_t e;
    if (drive_low === 1'b1 && p_start < 0) begin
      p_start = cyc;
    end else if (drive_low !== 1'b1 && p_start >= 0) begin
      if (exp_p.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: start %0d len %0d, none expected",
                 p_start, cyc - p_start);
      end else begin
        e = exp_p.pop_front();
        chk("pulse_start", p_start, e.at);
        chk("pulse_len", cyc - p_start, e.len);
      end
      p_start = -1;
    end
  end

  always @(negedge clk) begin
    done_t e;
    if (done === 1'b1) begin
      if (exp_d.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: at cycle %0d, none expected", cyc);
      end else begin
        e = exp_d.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("done_rdata", rdata, e.rd);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_d.size() != 0 || exp_p.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_d.size() != 0 || exp_p.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: %0d done and %0d pulses still pending",
               exp_d.size(), exp_p.size());
      exp_d.delete();
      exp_p.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Issue one transaction; slots is the clamped slot count.
  task automatic run_txn(input logic m, input logic [3:0] nb,
                         input logic [7:0] wd, input int slots,
                         input logic [7:0] mask, input logic [7:0] exp_rd);
    int acc;
    int len;
    acc = cyc + 1;
    for (int k = 0; k < slots; k++) begin
      len = (m == 1'b0 && !wd[k]) ? W0 : W1;
      exp_p.push_back(pulse_t'{acc + k * SLOT, len});
    end
    exp_d.push_back(done_t'{acc + slots * SLOT + 1, exp_rd});
    rd_mask = mask;
    rd_base = m ? acc : -1;
    mode  = m;
    nbits = nb;
    wdata = wd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(slots * SLOT + 50);
    rd_base = -1;
  endtask

  // Reset lands 500 cycles into slot 2; no done may follow.
  task automatic rst_mid(input logic m, input logic [7:0] wd,
                         input int len2, input logic [7:0] pre_rd);
    int acc;
    int n;
    acc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      exp_p.push_back(pulse_t'{acc + k * SLOT, m ? W1 : W0});
    end
    exp_p.push_back(pulse_t'{acc + 2 * SLOT, len2});
    rd_mask = 8'h00;
    rd_base = m ? acc : -1;
    mode  = m;
    nbits = 4'd8;
    wdata = wd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (cyc < acc + 2 * SLOT + 499 && n < 3 * SLOT) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_rdata", rdata, pre_rd);
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drive_low", drive_low, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    rd_base = -1;
    wait_idle(20);
    repeat (SLOT) @(negedge clk);
  endtask

  initial begin
    int acc;
    int acc2;
    int n;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_drive_low", drive_low, 0);
    chk("reset_rdata", rdata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_txn(1'b0, 4'd8, 8'hA5, 8, 8'h00, 8'h00);
    run_txn(1'b1, 4'd8, 8'h00, 8, 8'h0A, 8'hF5);
    run_txn(1'b1, 4'd0, 8'hFF, 0, 8'h00, 8'h00);
    run_txn(1'b0, 4'd12, 8'h3C, 8, 8'h00, 8'h00);
    run_txn(1'b1, 4'd3, 8'h00, 3, 8'h02, 8'h05);

    // start held high: FINISH-cycle start ignored, accepted after done
    acc  = cyc + 1;
    acc2 = acc + SLOT + 2;
    exp_p.push_back(pulse_t'{acc, W0});
    exp_d.push_back(done_t'{acc + SLOT + 1, 8'h00});
    exp_p.push_back(pulse_t'{acc2, W0});
    exp_d.push_back(done_t'{acc2 + SLOT + 1, 8'h00});
    mode  = 1'b0;
    nbits = 4'd1;
    wdata = 8'h00;
    start = 1'b1;
    n = 0;
    while (cyc < acc2 && n < 2 * SLOT) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_idle(2 * SLOT + 50);

    rst_mid(1'b0, 8'h00, 500, 8'h00);
    rst_mid(1'b1, 8'h00, W1, 8'h07);

    run_txn(1'b0, 4'd1, 8'h01, 1, 8'h00, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
